// File: rtl/square_load_sequencer.sv
// square_load_sequencer
// Feeds the WIDTH partial-product rows of A*A into a serial-load bank,
// MSB-first, one bit per row per cycle. It then waits out the compressor
// latency, captures the compressor outputs, and hands the result to the
// consumer through a valid/ready handshake.
`timescale 1ns/1ps

// One row lane. This is the registered serial bit for row k.
// Row k is A when A[k]=1 and zero otherwise. On each step the lane emits
// A[k] & (current column bit of A).
module square_load_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic upd,      // load next bit
    input  logic clr,      // force the bit low (end of load)
    input  logic row_bit,  // A[k]
    input  logic col_bit,  // A[WIDTH-1-c] for the bit being presented
    output logic bit_q
);
    // Registered so that the bank sees a glitch-free serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   bit_q <= 1'b0;
        else if (clr) bit_q <= 1'b0;
        else if (upd) bit_q <= row_bit & col_bit;
    end
endmodule

module square_load_sequencer #(
    parameter int WIDTH    = 24,
    parameter int OUT_W    = 29,
    parameter int COMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    output logic             sh_en,
    output logic [WIDTH-1:0] sh_bits,
    input  logic [OUT_W-1:0] cmp_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = (COMP_LAT > 0) ? $clog2(COMP_LAT + 1) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [SW-1:0] S_LAST = SW'(COMP_LAT);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;     // operand, selects which rows are live
    logic [WIDTH-1:0] col_q;   // operand shifted left once per LOAD edge; MSB = current column
    logic [CW-1:0]    c;       // bit counter inside LOAD
    logic [SW-1:0]    s;       // settle counter

    logic             accept;
    logic             lane_upd;
    logic             lane_clr;
    logic [WIDTH-1:0] row_src;
    logic             col_bit;

    // Next serial bit. The accept edge computes column 0 straight from
    // in_a, because a_q is not loaded yet. Later edges compute the next
    // column from the shifted copy.
    always_comb begin
        accept   = (state == IDLE) && in_valid;
        lane_clr = (state == LOAD) && (c == C_LAST);
        lane_upd = accept || ((state == LOAD) && (c != C_LAST));
        row_src  = accept ? in_a : a_q;
        col_bit  = accept ? in_a[WIDTH-1] : col_q[WIDTH-2];
    end

    genvar gk;
    generate
        for (gk = 0; gk < WIDTH; gk++) begin : g_lane
            square_load_lane u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .upd     (lane_upd),
                .clr     (lane_clr),
                .row_bit (row_src[gk]),
                .col_bit (col_bit),
                .bit_q   (sh_bits[gk])
            );
        end
    endgenerate

    // Sequencer FSM with registered handshake and control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            col_q     <= '0;
            c         <= '0;
            s         <= '0;
            in_ready  <= 1'b1;
            sh_en     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        col_q    <= in_a;
                        c        <= '0;
                        sh_en    <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    col_q <= {col_q[WIDTH-2:0], 1'b0};
                    if (c == C_LAST) begin
                        // The last shift happens on this edge, so the bank is complete after it
                        sh_en <= 1'b0;
                        s     <= '0;
                        state <= SETTLE;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                SETTLE: begin
                    if (s == S_LAST) begin
                        out_data  <= cmp_dst;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                DONE: begin
                    // out_data intentionally keeps its value after the handoff
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_square_load_sequencer.sv
// Bench for square_load_sequencer. It wraps two sequencers, each with its
// own enabled shift bank and a summing compressor. Instance 0 uses
// COMP_LAT=0 and instance 1 uses COMP_LAT=2. Row k of the bank must end up
// as (A[k] ? A : 0), and the compressor sum must equal popcount(A)*A.
`timescale 1ns/1ps

module tb_square_load_sequencer;
    localparam int W  = 24;
    localparam int OW = 29;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_err    = 0;

    logic          iv0, ir0, se0, ov0, ordy0, bz0;
    logic [W-1:0]  ia0, sb0;
    logic [OW-1:0] cd0, od0;
    logic [W-1:0]  bank0 [W];

    logic          iv1, ir1, se1, ov1, ordy1, bz1;
    logic [W-1:0]  ia1, sb1;
    logic [OW-1:0] cd1, od1, sum1, p1a, p1b;
    logic [W-1:0]  bank1 [W];

    square_load_sequencer #(.WIDTH(W), .OUT_W(OW), .COMP_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_a(ia0),
        .sh_en(se0), .sh_bits(sb0), .cmp_dst(cd0), .out_valid(ov0),
        .out_ready(ordy0), .out_data(od0), .busy(bz0));

    square_load_sequencer #(.WIDTH(W), .OUT_W(OW), .COMP_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(ia1),
        .sh_en(se1), .sh_bits(sb1), .cmp_dst(cd1), .out_valid(ov1),
        .out_ready(ordy1), .out_data(od1), .busy(bz1));

    // Enabled shift banks: srcK shifts in sh_bits[k] at its LSB
    always_ff @(posedge clk) begin
        if (se0) for (int k = 0; k < W; k++) bank0[k] <= {bank0[k][W-2:0], sb0[k]};
        if (se1) for (int k = 0; k < W; k++) bank1[k] <= {bank1[k][W-2:0], sb1[k]};
    end

    // Compressors: plain sum of all rows, combinational for instance 0
    always_comb begin
        cd0  = '0;
        sum1 = '0;
        for (int k = 0; k < W; k++) begin
            cd0  = cd0 + OW'(bank0[k]);
            sum1 = sum1 + OW'(bank1[k]);
        end
    end

    // Two-stage compressor pipeline for instance 1
    always_ff @(posedge clk) begin
        p1a <= sum1;
        p1b <= p1a;
    end
    assign cd1 = p1b;

    function automatic logic [OW-1:0] model(input logic [W-1:0] a);
        return OW'($countones(a)) * OW'(a);
    endfunction

    function automatic logic [W-1:0] row(input logic [W-1:0] a, input int k);
        return a[k] ? a : '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation on instance 0. The bench stalls the consumer for
    // `stall` cycles. When `hold` is set, in_valid stays high with `nxt`
    // as the next operand.
    task automatic op0(input logic [W-1:0] a, input int stall, input bit hold,
                       input logic [W-1:0] nxt);
        int lat;
        logic [OW-1:0] held;
        @(negedge clk);
        chk("in_ready_idle", 64'(ir0), 64'(1));
        iv0   = 1'b1;
        ia0   = a;
        ordy0 = (stall == 0);
        @(posedge clk); #1;
        if (hold) ia0 = nxt;
        else begin
            iv0 = 1'b0;
            ia0 = W'($urandom);
        end
        lat = 0;
        while (!ov0 && lat < 100) begin
            chk("busy", 64'(bz0), 64'(1));
            chk("in_ready_busy", 64'(ir0), 64'(0));
            if (lat < W) begin
                chk("sh_en_load", 64'(se0), 64'(1));
                chk("sh_bits_load", 64'(sb0), 64'(a[W-1-lat] ? a : '0));
            end else begin
                chk("sh_en_settle", 64'(se0), 64'(0));
                chk("sh_bits_settle", 64'(sb0), 64'(0));
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(W + 1));
        chk("out_data", 64'(od0), 64'(model(a)));
        for (int k = 0; k < W; k++) chk("bank_row", 64'(bank0[k]), 64'(row(a, k)));
        held = model(a);
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(ov0), 64'(1));
            chk("stall_data", 64'(od0), 64'(held));
            chk("stall_in_ready", 64'(ir0), 64'(0));
            chk("stall_busy", 64'(bz0), 64'(1));
        end
        ordy0 = 1'b1;
        @(posedge clk); #1;
        chk("ret_valid", 64'(ov0), 64'(0));
        chk("ret_in_ready", 64'(ir0), 64'(1));
        chk("ret_busy", 64'(bz0), 64'(0));
        chk("ret_data_kept", 64'(od0), 64'(held));
    endtask

    // Run one operation on instance 1 (COMP_LAT=2). The bench pulses
    // in_valid at random while the operation is in flight.
    task automatic op1(input logic [W-1:0] a);
        int lat;
        @(negedge clk);
        chk("c2_in_ready_idle", 64'(ir1), 64'(1));
        iv1   = 1'b1;
        ia1   = a;
        ordy1 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ov1 && lat < 100) begin
            chk("c2_in_ready_busy", 64'(ir1), 64'(0));
            chk("c2_busy", 64'(bz1), 64'(1));
            iv1 = 1'($urandom_range(0, 1));
            ia1 = W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        iv1 = 1'b0;
        chk("c2_latency", 64'(lat), 64'(W + 3));
        chk("c2_out_data", 64'(od1), 64'(model(a)));
        for (int k = 0; k < W; k++) chk("c2_bank_row", 64'(bank1[k]), 64'(row(a, k)));
        @(posedge clk); #1;
        chk("c2_ret_valid", 64'(ov1), 64'(0));
        chk("c2_ret_in_ready", 64'(ir1), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; ia0 = '0; ordy0 = 1'b0;
        iv1 = 1'b0; ia1 = '0; ordy1 = 1'b0;
        #12;
        chk("rst_in_ready", 64'(ir0), 64'(1));
        chk("rst_sh_en", 64'(se0), 64'(0));
        chk("rst_sh_bits", 64'(sb0), 64'(0));
        chk("rst_out_valid", 64'(ov0), 64'(0));
        chk("rst_out_data", 64'(od0), 64'(0));
        chk("rst_busy", 64'(bz0), 64'(0));
        chk("rst_c2_in_ready", 64'(ir1), 64'(1));
        chk("rst_c2_busy", 64'(bz1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single low bit, then the two end rows
        op0(24'h000001, 0, 1'b0, '0);
        op0(24'h800001, 0, 1'b0, '0);
        // All ones with the consumer stalled for 10 cycles
        op0(24'hFFFFFF, 10, 1'b0, '0);
        // Back-to-back operations with in_valid held high
        op0(24'h123456, 0, 1'b1, 24'hABCDEF);
        op0(24'hABCDEF, 0, 1'b0, '0);
        op0(24'h000000, 0, 1'b0, '0);

        // Reset asserted partway through LOAD
        @(negedge clk);
        iv0 = 1'b1;
        ia0 = 24'hFFFFFF;
        ordy0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_sh_en", 64'(se0), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(ir0), 64'(1));
        chk("arst_sh_en", 64'(se0), 64'(0));
        chk("arst_sh_bits", 64'(sb0), 64'(0));
        chk("arst_out_valid", 64'(ov0), 64'(0));
        chk("arst_out_data", 64'(od0), 64'(0));
        chk("arst_busy", 64'(bz0), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        op0(24'h00F00F, 0, 1'b0, '0);

        // Random operands with random consumer stalls
        for (int i = 0; i < 5; i++)
            op0(W'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);

        // Instance with COMP_LAT=2
        op1(24'h000003);
        op1(W'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
